// File: rtl/writeback_buffer_if.sv
// writeback_buffer_if
// Bundles the three traffic groups that cross the writeback buffer boundary:
//   wb_*     : cache -> buffer dirty-line push (valid/ready)
//   lookup_* : cache miss address probe, answered combinationally
//   mem_*    : buffer -> memory write request (req/ack)
// Modports:
//   master : the cache/memory side (drives pushes, lookups and acks)
//   slave  : the writeback buffer itself
interface writeback_buffer_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  wb_valid;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic                  wb_ready;

    logic                  lookup_valid;
    logic [ADDR_WIDTH-1:0] lookup_addr;
    logic                  lookup_hit;

    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ack;

    modport master (
        output wb_valid, wb_addr, lookup_valid, lookup_addr, mem_ack,
        input  wb_ready, lookup_hit, mem_req, mem_addr
    );

    modport slave (
        input  wb_valid, wb_addr, lookup_valid, lookup_addr, mem_ack,
        output wb_ready, lookup_hit, mem_req, mem_addr
    );
endinterface

// File: rtl/writeback_buffer.sv
// writeback_buffer
// Dirty-line writeback buffer sitting behind the cache. The cache pushes the
// line address of each dirty eviction and moves on; entries drain in FIFO
// order to memory one request at a time. Pushes of a line already waiting
// (and not yet in flight) are merged instead of allocating a new entry, and
// the cache can probe a miss address for a read-after-writeback hazard.
// Ports:
//   clk, rst       : clock (rising edge), asynchronous active-high reset
//   bus (slave)    : wb_valid/wb_addr/wb_ready push, lookup_valid/
//                    lookup_addr/lookup_hit probe, mem_req/mem_addr/mem_ack
//   count          : number of valid entries
//   full, empty    : count == DEPTH, count == 0
//   drained_count  : saturating total of entries written to memory
//   merged_count   : saturating total of pushes absorbed by merging
module writeback_buffer #(
    parameter int DEPTH      = 4,
    parameter int LINE_SIZE  = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    writeback_buffer_if.slave      bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic [31:0]            drained_count,
    output logic [31:0]            merged_count
);
    localparam int OFFSET_W = $clog2(LINE_SIZE);
    localparam int LINE_W   = ADDR_WIDTH - OFFSET_W;
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    logic [LINE_W-1:0]     line_q [DEPTH];
    logic [LINE_W-1:0]     line_d [DEPTH];
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic [31:0]           drained_q, drained_d;
    logic [31:0]           merged_q, merged_d;

    state_t                state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

    logic [LINE_W-1:0]     wb_line;
    logic [LINE_W-1:0]     lookup_line;
    logic                  in_flight;
    logic                  merge_hit;
    logic                  lookup_match;
    logic                  push_acc;
    logic                  do_merge;
    logic                  do_alloc;
    logic                  do_pop;
    logic                  unused_offset_bits;

    assign wb_line     = bus.wb_addr[ADDR_WIDTH-1:OFFSET_W];
    assign lookup_line = bus.lookup_addr[ADDR_WIDTH-1:OFFSET_W];

    // Offset bits select a byte inside the line and never matter here.
    assign unused_offset_bits = ^{bus.wb_addr[OFFSET_W-1:0],
                                  bus.lookup_addr[OFFSET_W-1:0]};

    // The head entry is in flight for as long as the request is outstanding.
    assign in_flight = (state_q == ISSUE);

    // Associative compare against every entry. Merging skips the in-flight
    // head (memory may already hold the old data), but the hazard lookup must
    // still see it until it is acknowledged.
    always_comb begin
        merge_hit    = 1'b0;
        lookup_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (line_q[i] == wb_line) &&
                !(in_flight && (PTR_W'(i) == rd_ptr_q))) begin
                merge_hit = 1'b1;
            end
            if (valid_q[i] && (line_q[i] == lookup_line)) begin
                lookup_match = 1'b1;
            end
        end
    end

    // Space is judged on the registered full flag, so a pop in the same
    // cycle cannot make room for a push.
    assign push_acc = bus.wb_valid && !full_q;
    assign do_merge = push_acc && merge_hit;
    assign do_alloc = push_acc && !merge_hit;
    assign do_pop   = in_flight && bus.mem_ack;

    // FIFO bookkeeping: pop clears the head, allocation fills the tail.
    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        line_d   = line_q;
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end
        if (do_alloc) begin
            valid_d[wr_ptr_q] = 1'b1;
            line_d[wr_ptr_q]  = wb_line;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        count_d   = count_q + CNT_W'(do_alloc) - CNT_W'(do_pop);
        full_d    = (count_d == CNT_W'(DEPTH));
        empty_d   = (count_d == '0);
        drained_d = (do_pop && (drained_q != 32'hFFFF_FFFF)) ?
                    drained_q + 32'd1 : drained_q;
        merged_d  = (do_merge && (merged_q != 32'hFFFF_FFFF)) ?
                    merged_q + 32'd1 : merged_q;
    end

    // Storage, pointers, occupancy flags and statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                line_q[i] <= '0;
            end
            valid_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            drained_q <= '0;
            merged_q  <= '0;
        end else begin
            line_q    <= line_d;
            valid_q   <= valid_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            drained_q <= drained_d;
            merged_q  <= merged_d;
        end
    end

    // Drain FSM state register, together with its registered outputs.
    // Reset drops any outstanding request immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Drain FSM next state. Returning to IDLE after every ack forces one
    // request-low cycle between transactions.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty_q)   state_d = ISSUE;
            ISSUE:   if (bus.mem_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Drain FSM outputs. The address is captured once on leaving IDLE and
    // then held for the whole request.
    always_comb begin
        mem_req_d  = (state_d == ISSUE);
        mem_addr_d = mem_addr_q;
        if ((state_q == IDLE) && !empty_q) begin
            mem_addr_d = {line_q[rd_ptr_q], {OFFSET_W{1'b0}}};
        end
    end

    assign bus.wb_ready   = !full_q;
    assign bus.lookup_hit = bus.lookup_valid && lookup_match;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;

    assign count          = count_q;
    assign full           = full_q;
    assign empty          = empty_q;
    assign drained_count  = drained_q;
    assign merged_count   = merged_q;
endmodule

// File: doc/writeback_buffer.md
Name: writeback_buffer

Overview:
Dirty-line writeback buffer directly downstream of the set-associative cache model.
- The cache pushes the line address of every dirty eviction or dirty invalidate here and does not wait on memory.
- Entries drain in FIFO order to the memory port over a req/ack handshake.
- The cache can look up a miss address, detecting a read-after-writeback hazard against pending lines.

Parameters:
depth, 4, number of buffered line entries (power of 2, 2..16)
line_size, 64, line size in bytes (32..128); byte-offset width = log2(line_size)
addr_width, 32, address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
wb_valid  in  1  cache presents a dirty line for writeback
wb_addr  in  addr_width  byte address of evicted line; offset bits ignored
wb_ready  out  1  buffer accepts wb_addr this cycle
lookup_valid  in  1  cache miss lookup request
lookup_addr  in  addr_width  miss byte address; offset bits ignored
lookup_hit  out  1  line matches any valid entry, including in-flight
mem_req  out  1  write request to memory
mem_addr  out  addr_width  line-aligned address of head entry, offset bits 0
mem_ack  in  1  memory accepted request
count  out  log2(depth)+1  valid entries
full  out  1  count == depth
empty  out  1  count == 0
drained_count  out  32  total entries written to memory
merged_count  out  32  writebacks absorbed by merging

Behaviour:
- Reset, async, immediate:
  - All entries invalid; pointers 0; count 0; full 0; empty 1.
  - mem_req 0; mem_addr 0; drained_count 0; merged_count 0; FSM in IDLE.
- Storage: circular FIFO of line addresses (addr >> log2(line_size)) with per-entry valid.
- wb_ready = !full, combinational. A pop in the same cycle does not free space for a push.
- Enqueue occurs when wb_valid && wb_ready:
  - Merge case: line equals a valid entry that is not in flight. No allocation; merged_count += 1.
  - Otherwise allocate at wr_ptr; wr_ptr wraps at depth. This includes a match only against the in-flight head.
- lookup_hit = lookup_valid && (line matches any valid entry). Combinational, same cycle, and it sees the buffer state before this cycle's edge.
- Drain FSM, registered outputs:
  - IDLE: mem_req 0. If !empty, load mem_addr from head and go to ISSUE next cycle.
  - ISSUE: mem_req 1 and mem_addr held stable until mem_ack. On mem_ack: pop head, rd_ptr wraps, drained_count += 1, next state IDLE.
  - IDLE always inserts one mem_req-low cycle between transactions, so throughput is at most 1 entry per 2 cycles.
  - mem_ack while in IDLE is ignored.
- An entry entering ISSUE is in flight; it is excluded from merging but included in lookup_hit until popped.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Merge and pop in the same cycle: count decrements by 1.
- count, full and empty are registered and consistent with the post-edge state.
- drained_count and merged_count saturate at 0xFFFFFFFF.
- Reset mid-ISSUE: the request is dropped, mem_req falls asynchronously, and the entry is lost. This is the intended behaviour.

Test Plan:
1. Fill with mem_ack=0: push 0x0000, 0x0040, 0x0080, 0x00C0 on consecutive cycles.
   -> count=4, full=1, wb_ready=0; mem_req=1, mem_addr=0x0000; a fifth push 0x0100 is not accepted.
2. Drain order: from scenario 1, pulse mem_ack each time mem_req=1.
   -> mem_addr sequence 0x0000, 0x0040, 0x0080, 0x00C0; mem_req low one cycle between each; drained_count=4; empty=1.
3. Merge: with 0x1000 in flight, push 0x2000 and then 0x2010.
   -> count=2, merged_count=1. Then push 0x1020, which matches only the in-flight line.
   -> allocated, count=3, merged_count=1.
4. Lookup: with entries 0x3000 (in flight) and 0x4000, issue lookup_addr 0x3004, 0x4038 and 0x5000.
   -> lookup_hit 1, 1, 0 in the same cycle; lookup_valid=0 -> lookup_hit 0.
5. Simultaneous events: count=2, in ISSUE; assert mem_ack and push new line 0x6000 in the same cycle.
   -> count stays 2, drained_count += 1, the new entry sits at the tail.
   - Repeat at full=1 -> push refused, count=3.
6. Reset mid-operation: assert rst while mem_req=1 with count=3.
   -> mem_req=0 before the next edge, count=0, empty=1, counters 0.
   - After release with mem_ack held 1, no request is issued until a new push.
